// File: rtl/ctr_seq_pkg.sv
// Shared types and defaults for the ctr_seq event-counter controller.
// Opcode and state encodings are used by the top and by the prescaler sub-block.
package ctr_seq_pkg;

    localparam int CTR_WIDTH_DEF = 8;
    localparam int PSC_WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        OP_NOP            = 3'd0,
        OP_LOAD           = 3'd1,
        OP_SET_TOP        = 3'd2,
        OP_SET_PSC        = 3'd3,
        OP_START_ONESHOT  = 3'd4,
        OP_START_PERIODIC = 3'd5,
        OP_STOP           = 3'd6,
        OP_CLEAR          = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // While running only these opcodes may be accepted; the rest stall.
    function automatic logic op_allowed_in_run(input op_e op);
        return (op == OP_NOP) || (op == OP_STOP) || (op == OP_CLEAR);
    endfunction

    function automatic logic op_is_start(input op_e op);
        return (op == OP_START_ONESHOT) || (op == OP_START_PERIODIC);
    endfunction

endpackage

// File: rtl/ctr_seq_psc.sv
// Prescaler for ctr_seq: counts enabled cycles and ticks every psc+1 of them.
// Holds its phase while disabled; clr returns it to zero.
module ctr_seq_psc
    import ctr_seq_pkg::*;
#(
    parameter int PSC_WIDTH = PSC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [PSC_WIDTH-1:0] psc,
    output logic                 tick
);

    logic [PSC_WIDTH-1:0] cnt_q;
    logic [PSC_WIDTH-1:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == psc);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ctr_seq.sv
// Command-driven sequencer for the 8-bit event counter (one-shot/periodic, pause, clear).
// Optional count capture is built in when CTR_SEQ_CAPTURE_EN is defined.
module ctr_seq
    import ctr_seq_pkg::*;
#(
    parameter int WIDTH     = CTR_WIDTH_DEF,
    parameter int PSC_WIDTH = PSC_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic             wrap,
    input  logic             cap_in,
    output logic [WIDTH-1:0] cap_value,
    output logic             cap_valid
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     top_q, top_d;
    logic [PSC_WIDTH-1:0] psc_q, psc_d;
    logic                 periodic_q, periodic_d;
    logic                 running_q, running_d;
    logic                 done_q, done_d;
    logic                 wrap_q, wrap_d;
    logic [WIDTH-1:0]     cap_value_q, cap_value_d;
    logic                 cap_valid_q, cap_valid_d;

    op_e  op;
    logic accept;
    logic psc_en;
    logic psc_clr;
    logic tick;

    // Handshake and prescaler control; kept apart from next-state logic
    // because tick feeds back from the prescaler.
    always_comb begin
        op        = op_e'(cmd_op);
        cmd_ready = (state_q != ST_RUN) || op_allowed_in_run(op);
        accept    = cmd_valid && cmd_ready;
        psc_en    = (state_q == ST_RUN) &&
                    !(accept && ((op == OP_STOP) || (op == OP_CLEAR)));
        psc_clr   = accept && ((op == OP_CLEAR) ||
                               (op_is_start(op) && (state_q != ST_PAUSE)));
    end

    ctr_seq_psc #(
        .PSC_WIDTH(PSC_WIDTH)
    ) u_psc (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (psc_en),
        .clr  (psc_clr),
        .psc  (psc_q),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        top_d      = top_q;
        psc_d      = psc_q;
        periodic_d = periodic_q;
        done_d     = 1'b0;
        wrap_d     = 1'b0;

        // tick is suppressed whenever a command is accepted in RUN, so the
        // tick and command branches below never both act.
        if (tick) begin
            if (count_q != top_q) begin
                count_d = count_q + 1'b1;
            end else if (periodic_q) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
        end

        if (accept) begin
            case (op)
                OP_LOAD: begin
                    count_d = cmd_data;
                    if (state_q == ST_DONE) state_d = ST_IDLE;
                end
                OP_SET_TOP: top_d = cmd_data;
                OP_SET_PSC: psc_d = cmd_data[PSC_WIDTH-1:0];
                OP_START_ONESHOT, OP_START_PERIODIC: begin
                    periodic_d = (op == OP_START_PERIODIC);
                    state_d    = ST_RUN;
                    if (state_q == ST_DONE) count_d = '0;
                end
                OP_STOP: begin
                    if (state_q == ST_RUN) state_d = ST_PAUSE;
                end
                OP_CLEAR: begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
                default: ;
            endcase
        end

        running_d = (state_d == ST_RUN);

`ifdef CTR_SEQ_CAPTURE_EN
        // Capture samples the count before this edge's update.
        cap_valid_d = cap_in;
        cap_value_d = cap_in ? count_q : cap_value_q;
`else
        cap_valid_d = 1'b0;
        cap_value_d = '0;
`endif
    end

`ifndef CTR_SEQ_CAPTURE_EN
    logic unused_cap_in;
    assign unused_cap_in = cap_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            top_q       <= '1;
            psc_q       <= '0;
            periodic_q  <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
            cap_value_q <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            top_q       <= top_d;
            psc_q       <= psc_d;
            periodic_q  <= periodic_d;
            running_q   <= running_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
            cap_value_q <= cap_value_d;
            cap_valid_q <= cap_valid_d;
        end
    end

    assign count     = count_q;
    assign running   = running_q;
    assign done      = done_q;
    assign wrap      = wrap_q;
    assign cap_value = cap_value_q;
    assign cap_valid = cap_valid_q;

endmodule

// File: tb/tb_ctr_seq.sv
// Directed scoreboard bench for ctr_seq: one expectation entry per clock step.
// Capture expectations follow CTR_SEQ_CAPTURE_EN.
module tb_ctr_seq;
    import ctr_seq_pkg::*;

`ifdef CTR_SEQ_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] count;
    logic       running;
    logic       done;
    logic       wrap;
    logic       cap_in;
    logic [7:0] cap_value;
    logic       cap_valid;

    typedef struct {
        logic [7:0] c;
        logic       r;
        logic       dn;
        logic       w;
        logic [7:0] cv;
        logic       cvl;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic [7:0] cap_exp_val = 8'd0;
    logic       cap_exp_vld = 1'b0;

    ctr_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .count    (count),
        .running  (running),
        .done     (done),
        .wrap     (wrap),
        .cap_in   (cap_in),
        .cap_value(cap_value),
        .cap_valid(cap_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one command for one clock, check ready, then check the registered outputs.
    task automatic cyc(input logic v, input logic [2:0] op, input logic [7:0] d,
                       input logic cap, input logic erdy, input logic [7:0] ec,
                       input logic er, input logic edn, input logic ew);
        exp_t e;
        @(negedge clk);
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        cap_in    = cap;
        #1;
        chk("cmd_ready", 32'(cmd_ready), 32'(erdy));
        sb.push_back('{c: ec, r: er, dn: edn, w: ew, cv: cap_exp_val, cvl: cap_exp_vld});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cap_in    = 1'b0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("count",     32'(count),     32'(e.c));
            chk("running",   32'(running),   32'(e.r));
            chk("done",      32'(done),      32'(e.dn));
            chk("wrap",      32'(wrap),      32'(e.w));
            chk("cap_value", 32'(cap_value), 32'(e.cv));
            chk("cap_valid", 32'(cap_valid), 32'(e.cvl));
        end
    endtask

    task automatic idle(input logic [7:0] ec, input logic er, input logic edn, input logic ew);
        cyc(1'b0, OP_NOP, 8'd0, 1'b0, 1'b1, ec, er, edn, ew);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = 8'd0;
        cap_in    = 1'b0;
        #12;
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_running",   32'(running),   32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_wrap",      32'(wrap),      32'd0);
        chk("rst_cap_value", 32'(cap_value), 32'd0);
        chk("rst_cap_valid", 32'(cap_valid), 32'd0);
        chk("rst_ready",     32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot to top=3 with psc=0
        cyc(1, OP_SET_TOP,       8'd3, 0, 1, 8'd0, 0, 0, 0);
        cyc(1, OP_START_ONESHOT, 8'd0, 0, 1, 8'd0, 1, 0, 0);
        idle(8'd1, 1, 0, 0);
        idle(8'd2, 1, 0, 0);
        idle(8'd3, 1, 0, 0);
        idle(8'd3, 0, 1, 0);
        idle(8'd3, 0, 0, 0);

        // Periodic, psc=2, top=1, restarted from DONE
        cyc(1, OP_SET_PSC,        8'd2, 0, 1, 8'd3, 0, 0, 0);
        cyc(1, OP_SET_TOP,        8'd1, 0, 1, 8'd3, 0, 0, 0);
        cyc(1, OP_START_PERIODIC, 8'd0, 0, 1, 8'd0, 1, 0, 0);
        idle(8'd0, 1, 0, 0);
        idle(8'd0, 1, 0, 0);
        idle(8'd1, 1, 0, 0);
        idle(8'd1, 1, 0, 0);
        idle(8'd1, 1, 0, 0);
        idle(8'd0, 1, 0, 1);
        idle(8'd0, 1, 0, 0);

        // LOAD stalls in RUN; STOP, LOAD, resume with prescaler phase kept
        cyc(1, OP_LOAD,           8'd5, 0, 0, 8'd0, 1, 0, 0);
        cyc(1, OP_LOAD,           8'd5, 0, 0, 8'd1, 1, 0, 0);
        cyc(1, OP_LOAD,           8'd5, 0, 0, 8'd1, 1, 0, 0);
        cyc(1, OP_STOP,           8'd0, 0, 1, 8'd1, 0, 0, 0);
        cyc(1, OP_LOAD,           8'd5, 0, 1, 8'd5, 0, 0, 0);
        cyc(1, OP_START_PERIODIC, 8'd0, 0, 1, 8'd5, 1, 0, 0);
        idle(8'd5, 1, 0, 0);
        idle(8'd6, 1, 0, 0);

        // STOP on a tick cycle at count 7
        cyc(1, OP_STOP,           8'd0,  0, 1, 8'd6, 0, 0, 0);
        cyc(1, OP_SET_PSC,        8'd0,  0, 1, 8'd6, 0, 0, 0);
        cyc(1, OP_SET_TOP,        8'd20, 0, 1, 8'd6, 0, 0, 0);
        cyc(1, OP_START_PERIODIC, 8'd0,  0, 1, 8'd6, 1, 0, 0);
        idle(8'd7, 1, 0, 0);
        cyc(1, OP_STOP,           8'd0,  0, 1, 8'd7, 0, 0, 0);
        idle(8'd7, 0, 0, 0);
        cyc(1, OP_CLEAR,          8'd0,  0, 1, 8'd0, 0, 0, 0);

        // top=0 one-shot: done on first tick, count stays 0
        cyc(1, OP_SET_TOP,       8'd0, 0, 1, 8'd0, 0, 0, 0);
        cyc(1, OP_START_ONESHOT, 8'd0, 0, 1, 8'd0, 1, 0, 0);
        idle(8'd0, 0, 1, 0);
        idle(8'd0, 0, 0, 0);

        // Run to 9, then asynchronous reset mid-run
        cyc(1, OP_LOAD,           8'd7,   0, 1, 8'd7, 0, 0, 0);
        cyc(1, OP_SET_TOP,        8'd200, 0, 1, 8'd7, 0, 0, 0);
        cyc(1, OP_START_PERIODIC, 8'd0,   0, 1, 8'd7, 1, 0, 0);
        idle(8'd8, 1, 0, 0);
        idle(8'd9, 1, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count",   32'(count),   32'd0);
        chk("async_rst_running", 32'(running), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // top back to all-ones: plain modulo counter with wrap at 255
        cyc(1, OP_LOAD,           8'd250, 0, 1, 8'd250, 0, 0, 0);
        cyc(1, OP_START_PERIODIC, 8'd0,   0, 1, 8'd250, 1, 0, 0);
        for (int i = 251; i <= 255; i++) idle(8'(i), 1, 0, 0);
        idle(8'd0, 1, 0, 1);
        idle(8'd1, 1, 0, 0);
        idle(8'd2, 1, 0, 0);
        idle(8'd3, 1, 0, 0);
        idle(8'd4, 1, 0, 0);

        // Capture on a tick cycle stores the pre-update count
        cap_exp_val = CAP ? 8'd4 : 8'd0;
        cap_exp_vld = CAP;
        cyc(0, OP_NOP, 8'd0, 1, 1, 8'd5, 1, 0, 0);
        cap_exp_vld = 1'b0;
        idle(8'd6, 1, 0, 0);
        cyc(1, OP_CLEAR, 8'd0, 0, 1, 8'd0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
